bsg_mem_1rw_sync_mask_write_bit_segmented_rmw: RTL and testbench

Segmented, synchronous, single-port memory with per-segment enables and bit-masked writes. It is built on plain 1RW storage that has no native bit mask. Partial-mask writes run as an internal two-cycle read-modify-write, and a ready/valid handshake stalls the requester during the merge. It replaces `bsg_mem_1rw_sync_mask_write_bit_segmented` wherever the target SRAM has no bit-write enable.

---
 rtl/bsg_mem_1rw_sync_mask_write_bit_segmented_rmw.sv | 225 ++++++++++++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_bit_segmented_rmw.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_segmented_rmw.sv
// bsg_mem_1rw_sync_mask_write_bit_segmented_rmw
//
// Segmented synchronous single-port memory with bit-masked writes, built on
// plain 1RW storage that has no native bit-write enable. A write whose mask
// covers only part of a segment is done as a two-cycle read-modify-write:
// the accept cycle reads the old word into a private register, and the
// following MERGE cycle writes back (old & ~mask) | (data & mask). While the
// merge is pending, ready_o is low and the requester must hold its request.
//
// Optional feature macro: BSG_MEM_1RW_SEG_RMW_SKIP_FULL_EN
//   defined   - writes where every active segment's mask is all-ones or
//               all-zeros complete in one cycle with no stall.
//   undefined - every write takes the read-modify-write path (uniform
//               2-cycle write timing).
//
// Ports:
//   clk_i     - clock
//   reset_i   - synchronous active-high reset
//   v_i       - per-segment request valid
//   w_i       - 1 = write, 0 = read
//   addr_i    - word address shared by all segments
//   data_i    - write data, segment k at [k*seg_w +: seg_w]
//   w_mask_i  - bit write mask, 1 = write the bit
//   ready_o   - request accepted when |v_i & ready_o
//   data_o    - read data
//   v_o       - data_o valid, one cycle after an accepted read

module bsg_mem_1rw_sync_mask_write_bit_segmented_rmw #(
    parameter  int width_p           = 32,
    parameter  int els_p             = 16,
    parameter  int num_segments_p    = 4,
    parameter  int latch_last_read_p = 0,
    localparam int lg_els_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [num_segments_p-1:0] v_i,
    input  logic                      w_i,
    input  logic [lg_els_lp-1:0]      addr_i,
    input  logic [width_p-1:0]        data_i,
    input  logic [width_p-1:0]        w_mask_i,
    output logic                      ready_o,
    output logic [width_p-1:0]        data_o,
    output logic                      v_o
);

    localparam int segment_width_lp = width_p / num_segments_p;

    typedef enum logic {
        ST_IDLE,
        ST_MERGE
    } state_e;

    state_e state_q, state_d;

    // Captured request for the merge cycle.
    logic [lg_els_lp-1:0]      addr_cap_q, addr_cap_d;
    logic [width_p-1:0]        data_cap_q, data_cap_d;
    logic [width_p-1:0]        mask_cap_q, mask_cap_d;
    logic [num_segments_p-1:0] v_cap_q,    v_cap_d;
    logic                      v_o_q,      v_o_d;

    logic                      ready;
    logic                      accept;
    logic                      rd_accept;
    logic                      wr_accept;
    logic                      skip_ok;
    logic                      direct_wr;
    logic                      rmw_start;
    logic                      merge_commit;
    logic [num_segments_p-1:0] mask_full;

    // Per-segment storage controls.
    logic [num_segments_p-1:0] rd_en;
    logic [num_segments_p-1:0] old_en;
    logic [num_segments_p-1:0] mem_we;
    logic [lg_els_lp-1:0]      mem_waddr;
    logic [width_p-1:0]        mem_wdata;
    logic [width_p-1:0]        old_word;
    logic [width_p-1:0]        merged_word;

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
    always_comb begin
        mask_full = '0;
        for (int unsigned k = 0; k < num_segments_p; k++) begin
            mask_full[k] = &w_mask_i[k*segment_width_lp +: segment_width_lp];
        end
    end

`ifdef BSG_MEM_1RW_SEG_RMW_SKIP_FULL_EN
    logic [num_segments_p-1:0] mask_zero;

    always_comb begin
        mask_zero = '0;
        for (int unsigned k = 0; k < num_segments_p; k++) begin
            mask_zero[k] = ~|w_mask_i[k*segment_width_lp +: segment_width_lp];
        end
        // Inactive segments never force the RMW path.
        skip_ok = &(~v_i | mask_full | mask_zero);
    end
`else
    always_comb begin
        skip_ok = 1'b0;
    end
`endif

    always_comb begin
        ready        = (state_q == ST_IDLE) & ~reset_i;
        accept       = (|v_i) & ready;
        rd_accept    = accept & ~w_i;
        wr_accept    = accept &  w_i;
        direct_wr    = wr_accept &  skip_ok;
        rmw_start    = wr_accept & ~skip_ok;
        // A reset landing on the merge cycle drops the pending write.
        merge_commit = (state_q == ST_MERGE) & ~reset_i;
    end

    // ------------------------------------------------------------------
    // FSM and capture registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_cap_d = addr_cap_q;
        data_cap_d = data_cap_q;
        mask_cap_d = mask_cap_q;
        v_cap_d    = v_cap_q;
        v_o_d      = rd_accept;

        case (state_q)
            ST_IDLE: begin
                if (rmw_start) begin
                    state_d    = ST_MERGE;
                    addr_cap_d = addr_i;
                    data_cap_d = data_i;
                    mask_cap_d = w_mask_i;
                    v_cap_d    = v_i;
                end
            end
            ST_MERGE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            v_o_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_o_q   <= v_o_d;
        end
        addr_cap_q <= addr_cap_d;
        data_cap_q <= data_cap_d;
        mask_cap_q <= mask_cap_d;
        v_cap_q    <= v_cap_d;
    end

    // ------------------------------------------------------------------
    // Storage port control
    // ------------------------------------------------------------------
    always_comb begin
        merged_word = (old_word & ~mask_cap_q) | (data_cap_q & mask_cap_q);
        mem_waddr   = (state_q == ST_MERGE) ? addr_cap_q : addr_i;
        mem_wdata   = merge_commit ? merged_word : data_i;
        rd_en       = '0;
        old_en      = '0;
        mem_we      = '0;
        for (int unsigned k = 0; k < num_segments_p; k++) begin
            rd_en[k]  = rd_accept & v_i[k];
            old_en[k] = rmw_start & v_i[k];
            // All-zero segments on the skip path are left untouched.
            mem_we[k] = (direct_wr & v_i[k] & mask_full[k])
                      | (merge_commit & v_cap_q[k]);
        end
    end

    // ------------------------------------------------------------------
    // Per-segment storage. Each segment uses its single port for at most one
    // of: user read, RMW old-word read, or write in any given cycle.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < num_segments_p; k++) begin : g_seg
        logic [segment_width_lp-1:0] mem_q [els_p];
        logic [segment_width_lp-1:0] old_q;
        logic [segment_width_lp-1:0] dout_q;

        always_ff @(posedge clk_i) begin
            if (mem_we[k]) begin
                mem_q[mem_waddr] <= mem_wdata[k*segment_width_lp +: segment_width_lp];
            end
            // RMW read lands here, never in data_o.
            if (old_en[k]) begin
                old_q <= mem_q[addr_i];
            end
        end

        if (latch_last_read_p != 0) begin : g_latch
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    dout_q <= '0;
                end else if (rd_en[k]) begin
                    dout_q <= mem_q[addr_i];
                end
            end
        end else begin : g_no_latch
            always_ff @(posedge clk_i) begin
                if (rd_en[k]) begin
                    dout_q <= mem_q[addr_i];
                end
            end
        end

        assign old_word[k*segment_width_lp +: segment_width_lp] = old_q;
        assign data_o[k*segment_width_lp +: segment_width_lp]   = dout_q;
    end

    assign ready_o = ready;
    assign v_o     = v_o_q;

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_segmented_rmw.sv
module tb_bsg_mem_1rw_sync_mask_write_bit_segmented_rmw;

    localparam int W  = 32;
    localparam int E  = 16;
    localparam int S  = 4;
    localparam int SW = W / S;

`ifdef BSG_MEM_1RW_SEG_RMW_SKIP_FULL_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_i;
    logic [S-1:0] v_i;
    logic         w_i;
    logic [3:0]   addr_i;
    logic [W-1:0] data_i;
    logic [W-1:0] w_mask_i;
    logic         ready_o;
    logic [W-1:0] data_o;
    logic         v_o;

    always #5 clk = ~clk;

    bsg_mem_1rw_sync_mask_write_bit_segmented_rmw #(
        .width_p          (W),
        .els_p            (E),
        .num_segments_p   (S),
        .latch_last_read_p(1)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .w_i     (w_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .w_mask_i(w_mask_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .v_o     (v_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: word array plus the visible read register.
    logic [W-1:0] ref_mem [E];
    logic [W-1:0] ref_dout;

    function automatic logic [W-1:0] seg_bits(input logic [S-1:0] v);
        logic [W-1:0] m;
        m = '0;
        for (int k = 0; k < S; k++) begin
            if (v[k]) m[k*SW +: SW] = {SW{1'b1}};
        end
        return m;
    endfunction

    function automatic int exp_stall(input logic [S-1:0] v, input logic [W-1:0] mask);
        logic [SW-1:0] s;
        if (!SKIP_EN) return 1;
        for (int k = 0; k < S; k++) begin
            s = mask[k*SW +: SW];
            if (v[k] && s != '0 && s != {SW{1'b1}}) return 1;
        end
        return 0;
    endfunction

    task automatic ref_write(input logic [S-1:0] v, input logic [3:0] a,
                             input logic [W-1:0] d, input logic [W-1:0] m);
        logic [W-1:0] mm;
        mm = m & seg_bits(v);
        ref_mem[a] = (ref_mem[a] & ~mm) | (d & mm);
    endtask

    task automatic ref_read(input logic [S-1:0] v, input logic [3:0] a);
        logic [W-1:0] vm;
        vm = seg_bits(v);
        ref_dout = (ref_dout & ~vm) | (ref_mem[a] & vm);
    endtask

    // Called at a negedge. Presents a request, waits for acceptance, then
    // returns v_o/data_o seen after the accept edge and the number of
    // cycles ready_o stayed low afterwards. Returns at a negedge.
    task automatic issue(input logic [S-1:0] v, input logic w, input logic [3:0] a,
                         input logic [W-1:0] d, input logic [W-1:0] m,
                         output int stall, output logic vo, output logic [W-1:0] dout);
        int n;
        v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m;
        n = 0;
        while (ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ready_o !== 1'b1) begin
            checks++; failures++;
            $display("FAIL issue_timeout ready_o=%b required 1", ready_o);
        end
        @(posedge clk);
        @(negedge clk);
        vo   = v_o;
        dout = data_o;
        v_i  = '0;
        stall = 0;
        while (ready_o !== 1'b1 && stall < 5) begin
            stall++;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input string name, input logic [S-1:0] v, input logic [3:0] a,
                            input logic [W-1:0] d, input logic [W-1:0] m);
        int st, es;
        logic vo;
        logic [W-1:0] dout;
        es = exp_stall(v, m);
        issue(v, 1'b1, a, d, m, st, vo, dout);
        ref_write(v, a, d, m);
        checks++;
        if (st !== es || vo !== 1'b0 || dout !== ref_dout) begin
            failures++;
            $display("FAIL %s write stall=%0d v_o=%b data_o=%h required stall=%0d v_o=0 data_o=%h",
                     name, st, vo, dout, es, ref_dout);
        end
    endtask

    task automatic do_read(input string name, input logic [S-1:0] v, input logic [3:0] a);
        int st;
        logic vo;
        logic [W-1:0] dout;
        issue(v, 1'b0, a, '0, '0, st, vo, dout);
        ref_read(v, a);
        checks++;
        if (st !== 0 || vo !== 1'b1 || dout !== ref_dout) begin
            failures++;
            $display("FAIL %s read stall=%0d v_o=%b data_o=%h required stall=0 v_o=1 data_o=%h",
                     name, st, vo, dout, ref_dout);
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1; v_i = '0; w_i = 1'b0; addr_i = '0; data_i = '0; w_mask_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || v_o !== 1'b0 || data_o !== '0) begin
            failures++;
            $display("FAIL reset_state ready_o=%b v_o=%b data_o=%h required 0 0 00000000",
                     ready_o, v_o, data_o);
        end
        reset_i = 1'b0;
        ref_dout = '0;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ready_o=%b v_o=%b required 1 0", ready_o, v_o);
        end
    endtask

    task automatic test_fill;
        for (int a = 0; a < E; a++) begin
            do_write("fill", 4'hF, 4'(a), $urandom, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_directed;
        int st;
        logic vo;
        logic [W-1:0] dout;
        // Full write then full read.
        do_write("s1", 4'hF, 4'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        issue(4'hF, 1'b0, 4'd3, '0, '0, st, vo, dout);
        ref_read(4'hF, 4'd3);
        checks++;
        if (vo !== 1'b1 || dout !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL s1_read v_o=%b data_o=%h required 1 deadbeef", vo, dout);
        end
        // Partial write: always one stall cycle.
        issue(4'b0011, 1'b1, 4'd3, 32'h1234_5678, 32'h0000_F0F0, st, vo, dout);
        ref_write(4'b0011, 4'd3, 32'h1234_5678, 32'h0000_F0F0);
        checks++;
        if (st !== 1) begin
            failures++;
            $display("FAIL s2_stall stall=%0d required 1", st);
        end
        issue(4'hF, 1'b0, 4'd3, '0, '0, st, vo, dout);
        ref_read(4'hF, 4'd3);
        checks++;
        if (vo !== 1'b1 || dout !== 32'hDEAD_5E7F) begin
            failures++;
            $display("FAIL s2_read v_o=%b data_o=%h required 1 dead5e7f", vo, dout);
        end
        // Single-segment full write.
        do_write("s3_clear", 4'hF, 4'd5, 32'h0, 32'hFFFF_FFFF);
        do_write("s3", 4'b0100, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(4'hF, 1'b0, 4'd5, '0, '0, st, vo, dout);
        ref_read(4'hF, 4'd5);
        checks++;
        if (vo !== 1'b1 || dout !== 32'h00FF_0000) begin
            failures++;
            $display("FAIL s3_read v_o=%b data_o=%h required 1 00ff0000", vo, dout);
        end
        // Hold last read through idle, then partial-segment read.
        issue(4'hF, 1'b0, 4'd3, '0, '0, st, vo, dout);
        ref_read(4'hF, 4'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (v_o !== 1'b0 || data_o !== 32'hDEAD_5E7F) begin
                failures++;
                $display("FAIL s4_hold v_o=%b data_o=%h required 0 dead5e7f", v_o, data_o);
            end
        end
        issue(4'b0001, 1'b0, 4'd5, '0, '0, st, vo, dout);
        ref_read(4'b0001, 4'd5);
        checks++;
        if (vo !== 1'b1 || dout !== 32'hDEAD_5E00) begin
            failures++;
            $display("FAIL s4_read v_o=%b data_o=%h required 1 dead5e00", vo, dout);
        end
    endtask

    task automatic test_reset_merge;
        do_write("s5_init", 4'hF, 4'd7, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        v_i = 4'hF; w_i = 1'b1; addr_i = 4'd7; data_i = 32'h5555_5555; w_mask_i = 32'h0F0F_0F0F;
        @(posedge clk);
        @(negedge clk);
        v_i = '0;
        reset_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0 || v_o !== 1'b0) begin
            failures++;
            $display("FAIL s5_merge_reset ready_o=%b v_o=%b required 0 0", ready_o, v_o);
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || v_o !== 1'b0 || data_o !== '0) begin
            failures++;
            $display("FAIL s5_in_reset ready_o=%b v_o=%b data_o=%h required 0 0 0", ready_o, v_o, data_o);
        end
        reset_i = 1'b0;
        ref_dout = '0;
        @(negedge clk);
        do_read("s5_after", 4'hF, 4'd7);
        // Request presented in the same cycle as reset must be ignored.
        reset_i = 1'b1;
        v_i = 4'hF; w_i = 1'b1; addr_i = 4'd7; data_i = 32'h0; w_mask_i = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_req ready_o=%b required 0", ready_o);
        end
        @(negedge clk);
        reset_i = 1'b0;
        v_i = '0;
        ref_dout = '0;
        @(negedge clk);
        do_read("reset_req_after", 4'hF, 4'd7);
    endtask

    task automatic test_random;
        logic [S-1:0] v;
        logic [3:0]   a;
        logic [W-1:0] d, m;
        for (int i = 0; i < 300; i++) begin
            v = 4'($urandom_range(1, 15));
            a = 4'($urandom_range(0, E - 1));
            d = $urandom;
            m = $urandom;
            for (int k = 0; k < S; k++) begin
                case ($urandom_range(0, 2))
                    0: m[k*SW +: SW] = '1;
                    1: m[k*SW +: SW] = '0;
                    default: ;
                endcase
            end
            if ($urandom_range(0, 1) == 1) do_write("random", v, a, d, m);
            else                           do_read("random", v, a);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] a, a_prev;
        a = 4'($urandom_range(0, E - 1));
        v_i = 4'hF; w_i = 1'b0; addr_i = a;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            a_prev = a;
            ref_read(4'hF, a_prev);
            checks++;
            if (v_o !== 1'b1 || data_o !== ref_dout || ready_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_read v_o=%b data_o=%h ready_o=%b required 1 %h 1",
                         v_o, data_o, ready_o, ref_dout);
            end
            a = 4'($urandom_range(0, E - 1));
            addr_i = a;
        end
        v_i = '0;
        for (int i = 0; i < 4; i++) begin
            do_write("b2b_write", 4'hF, 4'(i), $urandom, 32'hFFFF_FFFF);
        end
        for (int i = 0; i < 4; i++) begin
            do_read("b2b_check", 4'hF, 4'(i));
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_directed;
        test_reset_merge;
        test_random;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
